// File: rtl/alu_decoder_if.sv
// Handshake and ALU-control bundle between the fetch side, the decoder and the execute stage.
// The decoder takes the slave view; the producer/consumer pair takes the master view.
interface alu_decoder_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_op;
    logic            inv_zero;
    logic            src0_sel;
    logic [1:0]      src1_sel;
    logic            is_branch;
    logic            illegal;
    logic [XLEN-1:0] pc_out;

    modport master (
        output flush, in_valid, instr, pc_in, out_ready,
        input  in_ready, out_valid, alu_op, inv_zero, src0_sel, src1_sel,
               is_branch, illegal, pc_out
    );

    modport slave (
        input  flush, in_valid, instr, pc_in, out_ready,
        output in_ready, out_valid, alu_op, inv_zero, src0_sel, src1_sel,
               is_branch, illegal, pc_out
    );
endinterface

// File: rtl/alu_decoder.sv
// Registered RV32I decode stage producing the execute-stage ALU control bundle.
// A main register drives the outputs; a one-entry skid register keeps in_ready registered.
module alu_decoder #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_decoder_if.slave bus
);
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_LSL    = 4'd2;
    localparam logic [3:0] ALU_LT     = 4'd3;
    localparam logic [3:0] ALU_LTU    = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_LSR    = 4'd6;
    localparam logic [3:0] ALU_ASR    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_1 = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            inv_zero;
        logic            src0_sel;
        logic [1:0]      src1_sel;
        logic            is_branch;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    // Any unsupported encoding collapses to the neutral ADD bundle with illegal set.
    function automatic entry_t decode(input logic [31:0] w, input logic [XLEN-1:0] pc);
        entry_t     e;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       bad;
        e        = '0;
        e.alu_op = ALU_ADD;
        e.pc     = pc;
        f7       = w[31:25];
        f3       = w[14:12];
        bad      = 1'b0;
        case (w[6:0])
            OPC_OP, OPC_OPIMM: begin
                if (w[6:0] == OPC_OPIMM) e.src1_sel = 2'd1;
                else                     e.src1_sel = 2'd0;
                case (f3)
                    3'b000: begin
                        if (w[6:0] == OPC_OP && f7 == F7_ALT) e.alu_op = ALU_SUB;
                        else                                  e.alu_op = ALU_ADD;
                    end
                    3'b001: e.alu_op = ALU_LSL;
                    3'b010: e.alu_op = ALU_LT;
                    3'b011: e.alu_op = ALU_LTU;
                    3'b100: e.alu_op = ALU_XOR;
                    3'b101: begin
                        if (f7 == F7_ALT) e.alu_op = ALU_ASR;
                        else              e.alu_op = ALU_LSR;
                    end
                    3'b110: e.alu_op = ALU_OR;
                    default: e.alu_op = ALU_AND;
                endcase
                // OP-IMM only carries funct7 meaning on its shift encodings
                if (w[6:0] == OPC_OP || f3 == 3'b001 || f3 == 3'b101)
                    bad = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
                else
                    bad = 1'b0;
            end
            OPC_LUI: begin
                e.alu_op   = ALU_PASS_1;
                e.src1_sel = 2'd1;
            end
            OPC_AUIPC: begin
                e.src0_sel = 1'b1;
                e.src1_sel = 2'd1;
            end
            OPC_JAL, OPC_JALR: begin
                e.src0_sel = 1'b1;
                e.src1_sel = 2'd2;
            end
            OPC_LOAD, OPC_STORE: begin
                e.src1_sel = 2'd1;
            end
            OPC_BRANCH: begin
                e.is_branch = 1'b1;
                case (f3)
                    3'b000: begin e.alu_op = ALU_SUB; e.inv_zero = 1'b0; end
                    3'b001: begin e.alu_op = ALU_SUB; e.inv_zero = 1'b1; end
                    3'b100: begin e.alu_op = ALU_LT;  e.inv_zero = 1'b1; end
                    3'b101: begin e.alu_op = ALU_LT;  e.inv_zero = 1'b0; end
                    3'b110: begin e.alu_op = ALU_LTU; e.inv_zero = 1'b1; end
                    3'b111: begin e.alu_op = ALU_LTU; e.inv_zero = 1'b0; end
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e         = '0;
            e.alu_op  = ALU_ADD;
            e.illegal = 1'b1;
            e.pc      = pc;
        end else begin
            e.illegal = 1'b0;
        end
        return e;
    endfunction

    entry_t m_r, s_r, m_s, s_s, new_s;
    logic   m_valid_r, s_valid_r, in_ready_r;
    logic   m_valid_s, s_valid_s, accept_s, consume_s;
    logic   unused_instr_s;

    assign unused_instr_s = ^{bus.instr[24:15], bus.instr[11:7]};

    // Next-state of the main/skid pair; M refills from S first so order is preserved.
    always_comb begin
        new_s     = decode(bus.instr, bus.pc_in);
        accept_s  = bus.in_valid && in_ready_r;
        consume_s = m_valid_r && bus.out_ready;
        m_s       = m_r;
        s_s       = s_r;
        m_valid_s = m_valid_r;
        s_valid_s = s_valid_r;
        if (bus.flush) begin
            m_valid_s = 1'b0;
            s_valid_s = 1'b0;
        end else if (!m_valid_r || consume_s) begin
            if (s_valid_r) begin
                m_s       = s_r;
                m_valid_s = 1'b1;
                if (accept_s) begin
                    s_s       = new_s;
                    s_valid_s = 1'b1;
                end else begin
                    s_valid_s = 1'b0;
                end
            end else if (accept_s) begin
                m_s       = new_s;
                m_valid_s = 1'b1;
            end else begin
                m_valid_s = 1'b0;
            end
        end else if (accept_s) begin
            s_s       = new_s;
            s_valid_s = 1'b1;
        end else begin
            s_valid_s = s_valid_r;
        end
    end

    // Buffer registers; in_ready tracks skid-register vacancy after the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r        <= '0;
            s_r        <= '0;
            m_valid_r  <= 1'b0;
            s_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            m_r        <= m_s;
            s_r        <= s_s;
            m_valid_r  <= m_valid_s;
            s_valid_r  <= s_valid_s;
            in_ready_r <= !s_valid_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = m_valid_r;
    assign bus.alu_op    = m_r.alu_op;
    assign bus.inv_zero  = m_r.inv_zero;
    assign bus.src0_sel  = m_r.src0_sel;
    assign bus.src1_sel  = m_r.src1_sel;
    assign bus.is_branch = m_r.is_branch;
    assign bus.illegal   = m_r.illegal;
    assign bus.pc_out    = m_r.pc;
endmodule
